regfile_alu_sequencer: RTL

//  Command-side initiator for the 4x4 register file: accepts one instruction per handshake,

---
 rtl/regfile_alu_sequencer.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/regfile_alu_sequencer.sv
// Instruction sequencer for a small register file: fetches two operands, runs one
// ALU op and writes the result back, one instruction in flight, fixed 4-cycle latency.
module regfile_alu_sequencer #(
  parameter int DATA_W = 4,
  parameter int ADDR_W = 2
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           instr_valid,
  output logic                           instr_ready,
  input  logic [3+3*ADDR_W+DATA_W-1:0]   instr,
  output logic [ADDR_W-1:0]              rf_rd1,
  output logic [ADDR_W-1:0]              rf_rd2,
  input  logic [DATA_W-1:0]              rf_data_out1,
  input  logic [DATA_W-1:0]              rf_data_out2,
  output logic [ADDR_W-1:0]              rf_wr,
  output logic                           rf_write_enable,
  output logic [DATA_W-1:0]              rf_data_in,
  output logic                           done,
  output logic [DATA_W-1:0]              result,
  output logic                           flag_z,
  output logic                           flag_c
);

  localparam int IW = 3 + 3*ADDR_W + DATA_W;
  localparam logic [2:0] OP_CMP = 3'b111;

  typedef enum logic [1:0] {IDLE, READ, EXEC, WRITE} state_t;

  state_t              state;
  logic                rdy_q;
  logic                done_q;
  logic                we_q;
  logic [2:0]          op_p0;
  logic [ADDR_W-1:0]   dst_p0;
  logic [DATA_W-1:0]   imm_p0;
  logic [DATA_W-1:0]   opa_p1;
  logic [DATA_W-1:0]   opb_p1;
  logic [DATA_W:0]     alu_p2;

  logic [2:0]          in_op;
  logic [ADDR_W-1:0]   in_dst;
  logic [ADDR_W-1:0]   in_src1;
  logic [ADDR_W-1:0]   in_src2;
  logic [DATA_W-1:0]   in_imm;

  assign in_op   = instr[IW-1 -: 3];
  assign in_dst  = instr[DATA_W+3*ADDR_W-1 -: ADDR_W];
  assign in_src1 = instr[DATA_W+2*ADDR_W-1 -: ADDR_W];
  assign in_src2 = instr[DATA_W+ADDR_W-1 -: ADDR_W];
  assign in_imm  = instr[DATA_W-1:0];

  // MSB of the returned value is carry for ADD and borrow for SUB/CMP, zero otherwise
  function automatic logic [DATA_W:0] alu(input logic [2:0] op,
                                          input logic [DATA_W-1:0] a,
                                          input logic [DATA_W-1:0] b,
                                          input logic [DATA_W-1:0] imm);
    logic [DATA_W:0] r;
    r = '0;
    case (op)
      3'b000:         r = {1'b0, a} + {1'b0, b};
      3'b001, 3'b111: r = {1'b0, a} - {1'b0, b};
      3'b010:         r = {1'b0, a & b};
      3'b011:         r = {1'b0, a | b};
      3'b100:         r = {1'b0, a ^ b};
      3'b101:         r = {1'b0, ~a};
      3'b110:         r = {1'b0, imm};
      default:        r = '0;
    endcase
    return r;
  endfunction

  assign alu_p2 = alu(op_p0, opa_p1, opb_p1, imm_p0);

  // Strobes are masked by reset so nothing escapes during the reset cycle itself
  assign instr_ready     = rdy_q & ~reset;
  assign rf_write_enable = we_q & ~reset;
  assign done            = done_q & ~reset;

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      rdy_q      <= 1'b1;
      done_q     <= 1'b0;
      we_q       <= 1'b0;
      op_p0      <= '0;
      dst_p0     <= '0;
      imm_p0     <= '0;
      opa_p1     <= '0;
      opb_p1     <= '0;
      rf_rd1     <= '0;
      rf_rd2     <= '0;
      rf_wr      <= '0;
      rf_data_in <= '0;
      result     <= '0;
      flag_z     <= 1'b0;
      flag_c     <= 1'b0;
    end else begin
      case (state)
        // p0: latch the instruction and present read addresses for the READ cycle
        IDLE: begin
          if (instr_valid && rdy_q) begin
            op_p0  <= in_op;
            dst_p0 <= in_dst;
            imm_p0 <= in_imm;
            rf_rd1 <= in_src1;
            rf_rd2 <= in_src2;
            rdy_q  <= 1'b0;
            state  <= READ;
          end
        end
        // p1: capture operands before any write-back, so src==dst sees the old value
        READ: begin
          opa_p1 <= rf_data_out1;
          opb_p1 <= rf_data_out2;
          state  <= EXEC;
        end
        // p2: register ALU result into the write-back and status outputs
        EXEC: begin
          result     <= alu_p2[DATA_W-1:0];
          flag_z     <= (alu_p2[DATA_W-1:0] == '0);
          flag_c     <= alu_p2[DATA_W];
          rf_wr      <= dst_p0;
          rf_data_in <= alu_p2[DATA_W-1:0];
          we_q       <= (op_p0 != OP_CMP);
          done_q     <= 1'b1;
          state      <= WRITE;
        end
        WRITE: begin
          we_q   <= 1'b0;
          done_q <= 1'b0;
          rdy_q  <= 1'b1;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
